beepboop_xwalk_ctrl: RTL and testbench



---
 rtl/beepboop_xwalk_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_beepboop_xwalk_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/beepboop_xwalk_ctrl.sv
// beepboop_xwalk_ctrl: pedestrian crossing controller with prescaled
// phase timers, latched requests, pulsed beeper and night blink mode.

module beepboop_xwalk_ctrl #(
  parameter int TICK_DIV   = 1,
  parameter int CNT_W      = 16,
  parameter int T_YELLOW   = 200,
  parameter int T_ALL_RED  = 100,
  parameter int T_WALK     = 1200,
  parameter int FLASH_HALF = 100,
  parameter int NUM_FLASH  = 3,
  parameter int T_FINAL    = 100,
  parameter int MIN_GREEN  = 500,
  parameter int BEEP_HALF  = 0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       btn,
  input  logic       night_mode,
  output logic       red,
  output logic       yellow,
  output logic       green,
  output logic       walk,
  output logic       no_walk,
  output logic       beep,
  output logic       req_pending,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    S_GREEN  = 3'd0,
    S_YELLOW = 3'd1,
    S_ALLRED = 3'd2,
    S_WALK   = 3'd3,
    S_FLASH  = 3'd4,
    S_FINAL  = 3'd5,
    S_NIGHT  = 3'd6
  } state_e;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] D_YEL = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] D_AR = CNT_W'(T_ALL_RED - 1);
  localparam logic [CNT_W-1:0] D_WALK = CNT_W'(T_WALK - 1);
  localparam logic [CNT_W-1:0] D_FLASH =
    CNT_W'(2 * NUM_FLASH * FLASH_HALF - 1);
  localparam logic [CNT_W-1:0] D_FIN = CNT_W'(T_FINAL - 1);
  localparam logic [CNT_W-1:0] FH = CNT_W'(FLASH_HALF - 1);
  localparam logic [CNT_W-1:0] BH =
    CNT_W'((BEEP_HALF > 0) ? BEEP_HALF - 1 : 0);
  localparam logic [CNT_W-1:0] MG = CNT_W'(MIN_GREEN);

  state_e           state_q, state_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             s1_q, s2_q, s3_q;
  logic             req_q, req_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] gt_q, gt_d, gt_inc;
  logic [CNT_W-1:0] blk_q, blk_d;
  logic [CNT_W-1:0] bp_q, bp_d;
  logic             blk_ph_q, blk_ph_d;
  logic             bp_ph_q, bp_ph_d;
  logic             tick, btn_edge, enter;
  logic             timed, green_ok;

  assign tick = (pre_q == PRE_MAX);
  assign pre_d = tick ? '0 : pre_q + PW'(1);
  assign btn_edge = s2_q & ~s3_q;

  // A request is served once this tick completes MIN_GREEN green ticks.
  assign gt_inc = (gt_q == MG) ? gt_q : gt_q + CNT_W'(1);
  assign green_ok = (gt_inc == MG);

  assign timed = (state_q == S_YELLOW) || (state_q == S_ALLRED) ||
                 (state_q == S_WALK) || (state_q == S_FLASH) ||
                 (state_q == S_FINAL);

  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        S_GREEN: begin
          if (night_mode) state_d = S_NIGHT;
          else if (req_q && green_ok) state_d = S_YELLOW;
        end
        S_YELLOW: if (tmr_q == D_YEL) state_d = S_ALLRED;
        S_ALLRED: if (tmr_q == D_AR) state_d = S_WALK;
        S_WALK:   if (tmr_q == D_WALK) state_d = S_FLASH;
        S_FLASH:  if (tmr_q == D_FLASH) state_d = S_FINAL;
        S_FINAL:  if (tmr_q == D_FIN) state_d = S_GREEN;
        S_NIGHT:  if (!night_mode) state_d = S_GREEN;
        default:  state_d = S_GREEN;
      endcase
    end
  end

  assign enter = (state_d != state_q);

  always_comb begin
    tmr_d    = tmr_q;
    gt_d     = gt_q;
    blk_d    = blk_q;
    blk_ph_d = blk_ph_q;
    bp_d     = bp_q;
    bp_ph_d  = bp_ph_q;
    req_d    = req_q;
    if (btn_edge && (state_q != S_NIGHT)) req_d = 1'b1;
    if (enter) begin
      tmr_d    = '0;
      blk_d    = '0;
      blk_ph_d = 1'b0;
      bp_d     = '0;
      bp_ph_d  = 1'b0;
      if (state_d == S_GREEN) gt_d = '0;
      if ((state_d == S_YELLOW) || (state_d == S_NIGHT))
        req_d = 1'b0;
    end else if (tick) begin
      if (timed) tmr_d = tmr_q + CNT_W'(1);
      if (state_q == S_GREEN) gt_d = gt_inc;
      if ((state_q == S_FLASH) || (state_q == S_NIGHT)) begin
        if (blk_q == FH) begin
          blk_d    = '0;
          blk_ph_d = ~blk_ph_q;
        end else begin
          blk_d = blk_q + CNT_W'(1);
        end
      end
      if (state_q == S_WALK) begin
        if (bp_q == BH) begin
          bp_d    = '0;
          bp_ph_d = ~bp_ph_q;
        end else begin
          bp_d = bp_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_GREEN;
      pre_q    <= '0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      req_q    <= 1'b0;
      tmr_q    <= '0;
      gt_q     <= MG;
      blk_q    <= '0;
      blk_ph_q <= 1'b0;
      bp_q     <= '0;
      bp_ph_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      s1_q     <= btn;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      req_q    <= req_d;
      tmr_q    <= tmr_d;
      gt_q     <= gt_d;
      blk_q    <= blk_d;
      blk_ph_q <= blk_ph_d;
      bp_q     <= bp_d;
      bp_ph_q  <= bp_ph_d;
    end
  end

  always_comb begin
    red         = 1'b0;
    yellow      = 1'b0;
    green       = 1'b0;
    walk        = 1'b0;
    no_walk     = 1'b0;
    beep        = 1'b0;
    req_pending = req_q;
    phase       = state_q;
    case (state_q)
      S_GREEN: begin
        green   = 1'b1;
        no_walk = 1'b1;
      end
      S_YELLOW: begin
        yellow  = 1'b1;
        no_walk = 1'b1;
      end
      S_ALLRED: begin
        red     = 1'b1;
        no_walk = 1'b1;
      end
      S_WALK: begin
        red  = 1'b1;
        walk = 1'b1;
        beep = (BEEP_HALF == 0) ? 1'b1 : ~bp_ph_q;
      end
      S_FLASH: begin
        red     = 1'b1;
        no_walk = ~blk_ph_q;
      end
      S_FINAL: begin
        red     = 1'b1;
        no_walk = 1'b1;
      end
      S_NIGHT: begin
        yellow  = ~blk_ph_q;
        no_walk = 1'b1;
      end
      default: begin
        red     = 1'b1;
        no_walk = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_beepboop_xwalk_ctrl.sv
// Self-checking bench for beepboop_xwalk_ctrl: vector table, corner
// sequences and random stimulus against a tick-level behavioural model.

module tb_beepboop_xwalk_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] btn_v = '0;
  logic [2:0] night_v = '0;
  logic [9:0] out0, out1, out2;
  logic [9:0] o;

  always #5 clk = ~clk;

  beepboop_xwalk_ctrl u0 (
    .clock(clk), .reset_n(rst_n),
    .btn(btn_v[0]), .night_mode(night_v[0]),
    .red(out0[9]), .yellow(out0[8]), .green(out0[7]),
    .walk(out0[6]), .no_walk(out0[5]), .beep(out0[4]),
    .req_pending(out0[3]), .phase(out0[2:0])
  );

  beepboop_xwalk_ctrl #(.TICK_DIV(4), .BEEP_HALF(50)) u1 (
    .clock(clk), .reset_n(rst_n),
    .btn(btn_v[1]), .night_mode(night_v[1]),
    .red(out1[9]), .yellow(out1[8]), .green(out1[7]),
    .walk(out1[6]), .no_walk(out1[5]), .beep(out1[4]),
    .req_pending(out1[3]), .phase(out1[2:0])
  );

  beepboop_xwalk_ctrl #(
    .TICK_DIV(1), .CNT_W(4), .T_YELLOW(1), .T_ALL_RED(1),
    .T_WALK(1), .FLASH_HALF(1), .NUM_FLASH(1), .T_FINAL(1),
    .MIN_GREEN(0), .BEEP_HALF(0)
  ) u2 (
    .clock(clk), .reset_n(rst_n),
    .btn(btn_v[2]), .night_mode(night_v[2]),
    .red(out2[9]), .yellow(out2[8]), .green(out2[7]),
    .walk(out2[6]), .no_walk(out2[5]), .beep(out2[4]),
    .req_pending(out2[3]), .phase(out2[2:0])
  );

  int checks = 0;
  int errors = 0;
  int sel = 0;

  int c_div, c_yel, c_ar, c_walk, c_fh, c_nf, c_fin, c_mg, c_bh;
  int m_ph, m_t, m_g, m_pc;
  bit m_req;
  logic [2:0] m_h;

  typedef struct {
    int e;
    logic [2:0] ph;
    logic rq;
    logic nw;
    logic wk;
  } vec_t;
  vec_t tv[$];

  task automatic add_v(input int e, input int ph,
                       input bit rq, input bit nw, input bit wk);
    vec_t v;
    v.e = e;
    v.ph = ph[2:0];
    v.rq = rq;
    v.nw = nw;
    v.wk = wk;
    tv.push_back(v);
  endtask

  task automatic set_cfg(input int s);
    c_div = 1; c_yel = 200; c_ar = 100; c_walk = 1200;
    c_fh = 100; c_nf = 3; c_fin = 100; c_mg = 500; c_bh = 0;
    if (s == 1) begin
      c_div = 4;
      c_bh = 50;
    end else if (s == 2) begin
      c_yel = 1; c_ar = 1; c_walk = 1; c_fh = 1;
      c_nf = 1; c_fin = 1; c_mg = 0;
    end
  endtask

  function automatic int dur(input int p);
    case (p)
      1: return c_yel;
      2: return c_ar;
      3: return c_walk;
      4: return 2 * c_nf * c_fh;
      5: return c_fin;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_ph = 0; m_t = 0; m_g = c_mg;
    m_req = 0; m_pc = 0; m_h = '0;
  endtask

  task automatic model_step();
    bit tk, ed, bn, nt;
    int nph;
    bn = btn_v[sel];
    nt = night_v[sel];
    tk = (m_pc == c_div - 1);
    m_pc = tk ? 0 : m_pc + 1;
    ed = m_h[1] && !m_h[2];
    nph = m_ph;
    if (tk) begin
      if (m_ph == 0) begin
        if (nt) nph = 6;
        else if (m_req && (m_g + 1 >= c_mg)) nph = 1;
      end else if (m_ph == 6) begin
        if (!nt) nph = 0;
      end else if (m_t + 1 == dur(m_ph)) begin
        nph = (m_ph == 5) ? 0 : m_ph + 1;
      end
    end
    if (ed && m_ph != 6) m_req = 1;
    if (nph != m_ph) begin
      m_t = 0;
      if (nph == 1 || nph == 6) m_req = 0;
      if (nph == 0) m_g = 0;
    end else if (tk) begin
      m_t++;
      if (m_ph == 0) m_g = (m_g + 1 > c_mg) ? c_mg : m_g + 1;
    end
    m_h = {m_h[1:0], bn};
    m_ph = nph;
  endtask

  function automatic logic [9:0] exp_o();
    logic [9:0] e;
    logic [31:0] pv;
    bit fo, bon;
    fo = (m_t % (2 * c_fh)) < c_fh;
    bon = (c_bh == 0) ? 1'b1 : (((m_t / ((c_bh == 0) ? 1 : c_bh)) % 2) == 0);
    pv = m_ph;
    e = '0;
    e[2:0] = pv[2:0];
    e[3] = m_req;
    e[4] = (m_ph == 3) && bon;
    e[5] = (m_ph inside {0, 1, 2, 5, 6}) || (m_ph == 4 && fo);
    e[6] = (m_ph == 3);
    e[7] = (m_ph == 0);
    e[8] = (m_ph == 1) || (m_ph == 6 && fo);
    e[9] = (m_ph >= 2) && (m_ph <= 5);
    return e;
  endfunction

  function automatic logic [9:0] dut_o();
    case (sel)
      0: return out0;
      1: return out1;
      default: return out2;
    endcase
  endfunction

  function automatic int cur_ph();
    logic [9:0] t;
    t = dut_o();
    return int'(t[2:0]);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("model", 32'(dut_o()), 32'(exp_o()));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_async", 32'(dut_o()), 32'b0010100000);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_phase(input int p, input int maxc, input string nm);
    int k;
    k = 0;
    while (cur_ph() != p && k < maxc) begin
      cyc();
      k++;
    end
    checks++;
    if (cur_ph() != p) begin
      errors++;
      $display("FAIL %s timeout phase %0d want %0d", nm, cur_ph(), p);
    end
  endtask

  task automatic run_len(input int b, input logic v, input int maxc,
                         output int len);
    logic [9:0] t;
    len = 0;
    t = dut_o();
    while (t[b] == v && len < maxc) begin
      len++;
      cyc();
      t = dut_o();
    end
  endtask

  task automatic rand_run(input int n, input int bp, input int np,
                          input int rp);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(rp - 1) == 0) do_reset();
      btn_v[sel] = ($urandom_range(bp - 1) == 0);
      if ($urandom_range(np - 1) == 0) night_v[sel] = ~night_v[sel];
      cyc();
    end
    btn_v[sel] = 1'b0;
    night_v[sel] = 1'b0;
  endtask

  initial begin
    int vi, wcnt, len, k, idx, last;
    int seq[6];
    seq = '{1, 2, 3, 4, 5, 0};

    add_v(1, 0, 0, 1, 0);     add_v(2, 0, 1, 1, 0);
    add_v(3, 1, 0, 1, 0);     add_v(202, 1, 0, 1, 0);
    add_v(203, 2, 0, 1, 0);   add_v(302, 2, 0, 1, 0);
    add_v(303, 3, 0, 0, 1);   add_v(803, 3, 1, 0, 1);
    add_v(1502, 3, 1, 0, 1);  add_v(1503, 4, 1, 1, 0);
    add_v(1602, 4, 1, 1, 0);  add_v(1603, 4, 1, 0, 0);
    add_v(1703, 4, 1, 1, 0);  add_v(2102, 4, 1, 0, 0);
    add_v(2103, 5, 1, 1, 0);  add_v(2202, 5, 1, 1, 0);
    add_v(2203, 0, 1, 1, 0);  add_v(2702, 0, 1, 1, 0);
    add_v(2703, 1, 0, 1, 0);

    sel = 0;
    set_cfg(0);
    do_reset();
    vi = 0;
    wcnt = 0;
    btn_v[0] = 1'b1;
    for (int n = 0; n <= 2703; n++) begin
      cyc();
      btn_v[0] = (n + 1 == 800);
      o = dut_o();
      if (o[6] && o[4]) wcnt++;
      if (vi < tv.size() && tv[vi].e == n) begin
        chk($sformatf("vec%0d", n), {26'd0, o[2:0], o[3], o[5], o[6]},
            {26'd0, tv[vi].ph, tv[vi].rq, tv[vi].nw, tv[vi].wk});
        vi++;
      end
    end
    chk("vec_all", vi, tv.size());
    chk("walk_beep_len", wcnt, 1200);

    wait_phase(3, 400, "to_walk");
    repeat (50) cyc();
    do_reset();
    btn_v[0] = 1'b1;
    cyc();
    btn_v[0] = 1'b0;
    cyc();
    cyc();
    o = dut_o();
    chk("rst_req", {o[3], o[2:0]}, 4'b1000);
    cyc();
    chk("rst_no_wait", cur_ph(), 1);

    wait_phase(0, 3000, "to_green");
    btn_v[0] = 1'b1;
    cyc();
    btn_v[0] = 1'b0;
    repeat (5) cyc();
    o = dut_o();
    chk("green_req_held", {o[3], o[2:0]}, 4'b1000);
    night_v[0] = 1'b1;
    cyc();
    o = dut_o();
    chk("night_entry", {o[3], o[2:0]}, 4'b0110);
    run_len(8, 1'b1, 300, len);
    chk("night_yel_on", len, 100);
    run_len(8, 1'b0, 300, len);
    chk("night_yel_off", len, 100);
    btn_v[0] = 1'b1;
    cyc();
    btn_v[0] = 1'b0;
    repeat (5) cyc();
    o = dut_o();
    chk("night_btn_ignored", o[3], 0);
    night_v[0] = 1'b0;
    cyc();
    chk("night_exit", cur_ph(), 0);
    btn_v[0] = 1'b1;
    k = 0;
    while (cur_ph() != 1 && k < 1000) begin
      cyc();
      btn_v[0] = 1'b0;
      k++;
    end
    chk("min_green_wait", k, 500);

    rand_run(8000, 64, 1500, 4000);

    sel = 1;
    set_cfg(1);
    do_reset();
    btn_v[1] = 1'b1;
    cyc();
    btn_v[1] = 1'b0;
    wait_phase(1, 20, "div_yellow");
    run_len(8, 1'b1, 2000, len);
    chk("div_yellow_len", len, 800);
    wait_phase(3, 2000, "div_walk");
    run_len(4, 1'b1, 1000, len);
    chk("beep_high", len, 200);
    run_len(4, 1'b0, 1000, len);
    chk("beep_low", len, 200);
    wait_phase(0, 10000, "div_green");
    rand_run(3000, 64, 1500, 3000);

    sel = 2;
    set_cfg(2);
    do_reset();
    btn_v[2] = 1'b1;
    cyc();
    btn_v[2] = 1'b0;
    idx = 0;
    last = cur_ph();
    for (int i = 0; i < 40 && idx < 6; i++) begin
      cyc();
      if (cur_ph() != last) begin
        last = cur_ph();
        chk($sformatf("small_seq%0d", idx), last, seq[idx]);
        idx++;
      end
    end
    chk("small_done", idx, 6);
    rand_run(1500, 8, 60, 500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
